// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART TX FIFO write port among N_REQ byte streams.
// A grant lasts until req_last, or is cut by an idle timeout or a max-length guard (abort pulse).
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 1024,
  parameter int MAX_LEN = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DW-1:0]        req_data,
  input  logic [N_REQ-1:0]           req_last,
  output logic [N_REQ-1:0]           req_ready,
  input  logic                       tx_full,
  output logic                       wr_uart,
  output logic [DW-1:0]              wr_data,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic                       abort
);

  localparam int GW = $clog2(N_REQ);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = $clog2(TIMEOUT);

  typedef enum logic {
    IDLE,
    XFER
  } state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   rr_ptr, rr_ptr_nxt;
  logic [GW-1:0]   grant_nxt;
  logic [LW-1:0]   len_cnt, len_cnt_nxt;
  logic [IW-1:0]   idle_cnt, idle_cnt_nxt;
  logic            abort_nxt;
  logic            pick_valid;
  logic [GW-1:0]   pick_id;
  logic            sel_valid;
  logic            sel_last;
  logic            xfer;

  // Modulo-N_REQ addition; N_REQ need not be a power of two.
  function automatic logic [GW-1:0] wrap_add(input logic [GW-1:0] base, input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= N_REQ) sum = sum - N_REQ;
    return GW'(sum);
  endfunction

  // Round-robin pick: first valid requester starting at rr_ptr.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!pick_valid && req_valid[wrap_add(rr_ptr, k)]) begin
        pick_valid = 1'b1;
        pick_id    = wrap_add(rr_ptr, k);
      end
    end
  end

  assign busy      = (state == XFER);
  assign sel_valid = req_valid[grant_id];
  assign sel_last  = req_last[grant_id];
  assign xfer      = busy & sel_valid & ~tx_full;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[grant_id] = 1'b1;
    wr_uart = xfer;
    wr_data = busy ? req_data[int'(grant_id)*DW +: DW] : '0;
  end

  // NOTE: every variable written here gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    grant_nxt    = grant_id;
    len_cnt_nxt  = len_cnt;
    idle_cnt_nxt = idle_cnt;
    abort_nxt    = 1'b0;
    unique case (state)
      IDLE: begin
        len_cnt_nxt  = '0;
        idle_cnt_nxt = '0;
        if (pick_valid) begin
          grant_nxt = pick_id;
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (xfer) begin
          len_cnt_nxt  = len_cnt + 1'b1;
          idle_cnt_nxt = '0;
          // A byte that is both last and MAX_LEN-th is a normal release.
          if (sel_last || len_cnt == LW'(MAX_LEN - 1)) begin
            state_nxt    = IDLE;
            rr_ptr_nxt   = wrap_add(grant_id, 1);
            len_cnt_nxt  = '0;
            abort_nxt    = ~sel_last;
          end
        end else if (!sel_valid && !tx_full) begin
          if (idle_cnt == IW'(TIMEOUT - 1)) begin
            state_nxt    = IDLE;
            rr_ptr_nxt   = wrap_add(grant_id, 1);
            len_cnt_nxt  = '0;
            idle_cnt_nxt = '0;
            abort_nxt    = 1'b1;
          end else begin
            idle_cnt_nxt = idle_cnt + 1'b1;
          end
        end else begin
          // A full FIFO stalls the grant; that is not idleness.
          idle_cnt_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      len_cnt  <= '0;
      idle_cnt <= '0;
      abort    <= 1'b0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      grant_id <= grant_nxt;
      len_cnt  <= len_cnt_nxt;
      idle_cnt <= idle_cnt_nxt;
      abort    <= abort_nxt;
    end
  end

endmodule
